// File: rtl/ysyx_23060136_exu_mul_ctrl_pkg.sv
// ysyx_23060136_exu_mul_ctrl_pkg: shared op/state enums, cache and latched-op records, op decode helpers
package ysyx_23060136_exu_mul_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_e;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_e;
  localparam logic [2:0] MUL_CNT = 3'd4;
  typedef struct packed {
    mul_op_e     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  sgn;
    logic        w;
  } op_t;
  typedef struct packed {
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  sgn;
    logic        w;
    logic [63:0] hi;
    logic [63:0] lo;
  } cache_t;
  function automatic logic [1:0] op_sgn(mul_op_e op);
    return op == OP_MULHSU ? 2'b10 : op == OP_MULHU ? 2'b00 : 2'b11;
  endfunction
  function automatic logic op_hi(mul_op_e op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_MULHU;
  endfunction
endpackage

// File: rtl/ysyx_23060136_exu_mul_ctrl_if.sv
// ysyx_23060136_exu_mul_ctrl_if: EXU op/result handshake plus multiplier-side view; master=EXU, slave=controller
interface ysyx_23060136_exu_mul_ctrl_if;
  import ysyx_23060136_exu_mul_ctrl_pkg::*;
  logic        op_valid;
  logic        op_ready;
  mul_op_e     mul_op;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        mul_valid;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        mul_ready;
  logic        mul_out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;
  modport master (
    output op_valid, mul_op, rs1, rs2, flush, res_ready,
    input  op_ready, res_valid, res_data, mul_valid, mulw, mul_signed, multiplicand, multiplier,
    input  mul_ready, mul_out_valid, result_hi, result_lo
  );
  modport slave (
    input  op_valid, mul_op, rs1, rs2, flush, res_ready,
    output op_ready, res_valid, res_data, mul_valid, mulw, mul_signed, multiplicand, multiplier,
    output mul_ready, mul_out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_23060136_exu_mul_ctrl_mul.sv
// ysyx_23060136_exu_mul: 64x64 multiplier, out_valid five cycles after handshake and sticky until next op; clk/rst, valid/ready in, hi/lo out
module ysyx_23060136_exu_mul
  import ysyx_23060136_exu_mul_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_valid,
  input  logic        mulw,
  input  logic [1:0]  mul_signed,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  output logic        mul_ready,
  output logic        mul_out_valid,
  output logic [63:0] result_hi,
  output logic [63:0] result_lo
);
  logic busy_q, busy_d, done_q, done_d;
  logic [2:0] cnt_q, cnt_d;
  logic [63:0] hi_q, hi_d, lo_q, lo_d;
  logic [127:0] a_x, b_x, p;
  always_comb begin
    a_x = {{64{mul_signed[1] & multiplicand[63]}}, multiplicand};
    b_x = {{64{mul_signed[0] & multiplier[63]}}, multiplier};
    p = a_x * b_x;
    busy_d = busy_q;
    done_d = done_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_valid & ~busy_q) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      cnt_d = MUL_CNT;
      hi_d = p[127:64];
      lo_d = mulw ? {{32{p[31]}}, p[31:0]} : p[63:0];
    end else if (busy_q) begin
      cnt_d = cnt_q - 3'd1;
      busy_d = cnt_q != 3'd1;
      done_d = cnt_q == 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign mul_ready = ~busy_q;
  assign mul_out_valid = done_q;
  assign result_hi = hi_q;
  assign result_lo = lo_q;
endmodule

// File: rtl/ysyx_23060136_exu_mul_ctrl.sv
// ysyx_23060136_exu_mul_ctrl: M-ext multiply controller with one-entry result cache; clk/rst plus io (EXU op/result handshake, multiplier view)
module ysyx_23060136_exu_mul_ctrl
  import ysyx_23060136_exu_mul_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  ysyx_23060136_exu_mul_ctrl_if.slave io
);
  state_e state_q, state_d;
  op_t cur_q, cur_d;
  cache_t cache_q, cache_d;
  logic [63:0] res_q, res_d;
  logic mul_ready, mul_out_valid, accept, hit, new_w, fill;
  logic [1:0] new_sgn;
  logic [63:0] result_hi, result_lo;
  ysyx_23060136_exu_mul u_mul (
    .clk(clk), .rst(rst),
    .mul_valid(io.mul_valid), .mulw(cur_q.w), .mul_signed(cur_q.sgn),
    .multiplicand(cur_q.a), .multiplier(cur_q.b),
    .mul_ready(mul_ready), .mul_out_valid(mul_out_valid),
    .result_hi(result_hi), .result_lo(result_lo)
  );
  assign new_w = io.mul_op == OP_MULW;
  assign new_sgn = op_sgn(io.mul_op);
  assign hit = cache_q.v & io.rs1 == cache_q.a & io.rs2 == cache_q.b & new_w == cache_q.w &
               (~op_hi(io.mul_op) | new_sgn == cache_q.sgn);
  assign io.op_ready = state_q == S_IDLE & ~io.flush;
  assign accept = io.op_ready & io.op_valid;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    cache_d = cache_q;
    res_d = res_q;
    fill = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        cur_d = '{op: io.mul_op, a: io.rs1, b: io.rs2, sgn: new_sgn, w: new_w};
        state_d = hit ? S_DONE : S_ISSUE;
        res_d = op_hi(io.mul_op) ? cache_q.hi : cache_q.lo;
      end
      S_ISSUE: state_d = mul_ready ? (io.flush ? S_DRAIN : S_WAIT) : (io.flush ? S_IDLE : S_ISSUE);
      S_WAIT: if (mul_out_valid) begin
        fill = 1'b1;
        state_d = io.flush ? S_IDLE : S_DONE;
        res_d = op_hi(cur_q.op) ? result_hi : result_lo;
      end else if (io.flush) state_d = S_DRAIN;
      S_DONE: if (io.flush | io.res_ready) state_d = S_IDLE;
      S_DRAIN: if (mul_out_valid) begin
        fill = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (fill) cache_d = '{v: 1'b1, a: cur_q.a, b: cur_q.b, sgn: cur_q.sgn, w: cur_q.w, hi: result_hi, lo: result_lo};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q <= '0;
      cache_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      cache_q <= cache_d;
      res_q <= res_d;
    end
  end
  assign io.res_valid = state_q == S_DONE;
  assign io.res_data = res_q;
  assign io.mul_valid = state_q == S_ISSUE;
  assign io.mulw = cur_q.w;
  assign io.mul_signed = cur_q.sgn;
  assign io.multiplicand = cur_q.a;
  assign io.multiplier = cur_q.b;
  assign io.mul_ready = mul_ready;
  assign io.mul_out_valid = mul_out_valid;
  assign io.result_hi = result_hi;
  assign io.result_lo = result_lo;
endmodule

// File: tb/tb_ysyx_23060136_exu_mul_ctrl.sv
// tb_ysyx_23060136_exu_mul_ctrl: directed and random checks of the multiply controller against a latency/arithmetic model
module tb_ysyx_23060136_exu_mul_ctrl;
  import ysyx_23060136_exu_mul_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  always #5 clk = ~clk;
  ysyx_23060136_exu_mul_ctrl_if bus ();
  ysyx_23060136_exu_mul_ctrl dut (.clk(clk), .rst(rst), .io(bus));
  bit m_act = 1'b0, m_hit = 1'b0, m_drop = 1'b0, c_v = 1'b0;
  int m_rel = 0;
  logic [2:0] m_op = '0, c_op = '0;
  logic [63:0] m_a = '0, m_b = '0, m_val = '0, c_a = '0, c_b = '0;
  function automatic logic [63:0] ref_mul(logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic [127:0] sa, sb, p;
    sa = (op == 3'd1 || op == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    sb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p = sa * sb;
    return op == 3'd0 ? p[63:0] : op == 3'd4 ? {{32{p[31]}}, p[31:0]} : p[127:64];
  endfunction
  function automatic logic [1:0] sgn_of(logic [2:0] op);
    return op == 3'd2 ? 2'b10 : op == 3'd3 ? 2'b00 : 2'b11;
  endfunction
  function automatic bit is_hi(logic [2:0] op);
    return op >= 3'd1 && op <= 3'd3;
  endfunction
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic step_model();
    bit win, exp_rv, exp_mv;
    logic [2:0] op;
    win = m_act && (m_hit || m_rel >= 7);
    exp_rv = win && !m_drop;
    exp_mv = m_act && !m_hit && m_rel == 1;
    if (mon_en) begin
      chk("op_ready", 64'(bus.op_ready), 64'(!m_act && !bus.flush));
      chk("res_valid", 64'(bus.res_valid), 64'(exp_rv));
      chk("mul_valid", 64'(bus.mul_valid), 64'(exp_mv));
      if (exp_rv) chk("res_data", bus.res_data, m_val);
      if (exp_mv) begin
        chk("multiplicand", bus.multiplicand, m_a);
        chk("multiplier", bus.multiplier, m_b);
        chk("mulw", 64'(bus.mulw), 64'(m_op == 3'd4));
        chk("mul_signed", 64'(bus.mul_signed), 64'(sgn_of(m_op)));
      end
    end
    if (rst) begin
      m_act = 1'b0;
      c_v = 1'b0;
    end else if (!m_act) begin
      if (bus.op_valid && !bus.flush) begin
        op = bus.mul_op;
        m_op = op;
        m_a = bus.rs1;
        m_b = bus.rs2;
        m_val = ref_mul(op, bus.rs1, bus.rs2);
        m_hit = c_v && bus.rs1 == c_a && bus.rs2 == c_b && (op == 3'd4) == (c_op == 3'd4) &&
                (!is_hi(op) || sgn_of(op) == sgn_of(c_op));
        if (!m_hit) begin
          c_v = 1'b1;
          c_a = bus.rs1;
          c_b = bus.rs2;
          c_op = op;
        end
        m_act = 1'b1;
        m_rel = 1;
        m_drop = 1'b0;
      end
    end else begin
      if (!m_hit && m_rel >= 1 && m_rel <= 6 && bus.flush) m_drop = 1'b1;
      if ((!m_hit && m_rel == 6 && m_drop) || (win && (bus.flush || bus.res_ready))) m_act = 1'b0;
      m_rel++;
    end
  endtask
  task automatic drive(bit v, logic [2:0] op, logic [63:0] a, logic [63:0] b, bit fl, bit rr, bit r);
    bus.op_valid = v;
    bus.mul_op = mul_op_e'(op);
    bus.rs1 = a;
    bus.rs2 = b;
    bus.flush = fl;
    bus.res_ready = rr;
    rst = r;
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(logic [2:0] op, logic [63:0] a, logic [63:0] b, output int lat, output logic [63:0] d, output bit mv);
    lat = -1;
    d = '0;
    mv = 1'b0;
    drive(1'b1, op, a, b, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      if (bus.mul_valid) mv = 1'b1;
      if (bus.res_valid) begin
        lat = k;
        d = bus.res_data;
      end
      drive(1'b0, op, a, b, 1'b0, 1'b1, 1'b0);
    end
  endtask
  initial begin
    int lat;
    logic [63:0] d;
    bit mv, seen_rv, seen_rdy;
    logic [63:0] pool [4];
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst op_ready", 64'(bus.op_ready), 64'd1);
    chk("rst res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst mul_valid", 64'(bus.mul_valid), 64'd0);
    chk("rst mulw", 64'(bus.mulw), 64'd0);
    chk("rst mul_signed", 64'(bus.mul_signed), 64'd0);
    chk("rst multiplicand", bus.multiplicand, 64'd0);
    chk("rst multiplier", bus.multiplier, 64'd0);
    chk("rst res_data", bus.res_data, 64'd0);
    mon_en = 1'b1;
    run_op(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, lat, d, mv);
    chk("mul lat", 64'(lat), 64'd7);
    chk("mul data", d, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'd3, '1, '1, lat, d, mv);
    chk("mulhu lat", 64'(lat), 64'd7);
    chk("mulhu data", d, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd0, '1, '1, lat, d, mv);
    chk("hit lat", 64'(lat), 64'd1);
    chk("hit data", d, 64'd1);
    chk("hit mul_valid seen", 64'(mv), 64'd0);
    run_op(3'd4, 64'h7FFF_FFFF, 64'd2, lat, d, mv);
    chk("mulw lat", 64'(lat), 64'd7);
    chk("mulw data", d, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd0, 64'h7FFF_FFFF, 64'd2, lat, d, mv);
    chk("mul after mulw lat", 64'(lat), 64'd7);
    chk("mul after mulw data", d, 64'hFFFF_FFFE);
    drive(1'b1, 3'd1, 64'd5, -64'sd7, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd1, 64'd5, -64'sd7, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd1, 64'd5, -64'sd7, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd1, 64'd5, -64'sd7, 1'b1, 1'b1, 1'b0);
    seen_rv = 1'b0;
    seen_rdy = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      seen_rv |= bus.res_valid;
      seen_rdy |= bus.op_ready;
      drive(1'b0, 3'd1, 64'd5, -64'sd7, 1'b0, 1'b1, 1'b0);
    end
    chk("drain res_valid seen", 64'(seen_rv), 64'd0);
    chk("drain op_ready seen", 64'(seen_rdy), 64'd0);
    chk("drain release op_ready", 64'(bus.op_ready), 64'd1);
    run_op(3'd1, 64'd5, -64'sd7, lat, d, mv);
    chk("drain fill hit lat", 64'(lat), 64'd1);
    chk("drain fill hit data", d, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 3'd2, 64'h8000_0000_0000_0000, '1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20 && !bus.res_valid; k++) drive(1'b0, 3'd2, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 3'd2, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("hold res_valid", 64'(bus.res_valid), 64'd1);
    chk("hold res_data", bus.res_data, 64'h8000_0000_0000_0000);
    chk("hold op_ready", 64'(bus.op_ready), 64'd0);
    drive(1'b0, 3'd2, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("release op_ready", 64'(bus.op_ready), 64'd1);
    chk("release res_valid", 64'(bus.res_valid), 64'd0);
    run_op(3'd0, 64'h1234, 64'h10, lat, d, mv);
    chk("pre-rst data", d, 64'h12340);
    drive(1'b1, 3'd1, 64'h55, 64'h66, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd1, 64'h55, 64'h66, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd1, 64'h55, 64'h66, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd1, 64'h55, 64'h66, 1'b0, 1'b1, 1'b1);
    chk("post-rst op_ready", 64'(bus.op_ready), 64'd1);
    chk("post-rst res_valid", 64'(bus.res_valid), 64'd0);
    run_op(3'd0, 64'h1234, 64'h10, lat, d, mv);
    chk("post-rst lat", 64'(lat), 64'd7);
    chk("post-rst data", d, 64'h12340);
    pool[0] = 64'd0;
    pool[1] = 64'd3;
    pool[2] = '1;
    pool[3] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 63) pool[$urandom_range(3)] = {$urandom, $urandom};
      drive($urandom_range(1), 3'($urandom_range(4)), pool[$urandom_range(3)], pool[$urandom_range(3)],
            $urandom_range(11) == 0, $urandom_range(3) != 0, $urandom_range(199) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060136_exu_mul_ctrl.md
YSYX_23060136_EXU_MUL_CTRL -- requirements
Module: ysyx_23060136_EXU_MUL_CTRL

Interface
REQ-001 SHALL: clk  in  1  sole clock; rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-002 SHALL: op_valid  in  1  EXU presents an M-extension multiply op; op_ready  out  1  controller can accept an op.
REQ-003 SHALL: mul_op  in  3  op code (MUL, MULH, MULHSU, MULHU, MULW); rs1, rs2  in  64  source operands.
REQ-004 SHALL: flush  in  1  pipeline kill, in-flight op discarded.
REQ-005 SHALL: res_valid  out  1  result available; res_ready  in  1  downstream accepts; res_data  out  64  result.
REQ-006 SHALL: mul_valid  out  1; mulw  out  1; mul_signed  out  2; multiplicand, multiplier  out  64  (drive the 64-bit multiplier).
REQ-007 SHALL: mul_ready  in  1; mul_out_valid  in  1; result_hi, result_lo  in  64  (returned by the multiplier).

Function
REQ-008 SHALL: states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-009 SHALL: op_ready = IDLE & !flush; accept on op_valid & op_ready; rs1, rs2, mul_op latched at accept.
REQ-010 SHALL: mul_signed mapping: MULH/MUL/MULW -> 2'b11, MULHSU -> 2'b10, MULHU -> 2'b00; mulw = (op == MULW).
REQ-011 SHALL: cache: last completed multiply keeps rs1, rs2, mul_signed, mulw, result_hi, result_lo, plus a valid bit.
REQ-012 SHALL: hit rules: operands equal and cached mulw equal; MUL also requires cached mulw=0 (signedness ignored); MULH* also requires equal mul_signed.
REQ-013 SHALL: IDLE -> DONE on an accepted hit: res_data loads from the cache, res_valid rises the next cycle, mul_valid is not asserted.
REQ-014 SHALL: IDLE -> ISSUE on an accepted miss; in ISSUE mul_valid=1 with latched operands; ISSUE -> WAIT on mul_ready.
REQ-015 SHALL: in ISSUE the controller ignores mul_out_valid (stale, sticky from the previous op).
REQ-016 SHALL: WAIT -> DONE on mul_out_valid; in the same edge res_data loads (result_lo for MUL/MULW, result_hi for MULH*) and the cache fills.
REQ-017 SHALL: miss latency: accept at cycle 0, mul handshake at cycle 1, mul_out_valid at cycle 6, res_valid at cycle 7.
REQ-018 SHALL: res_valid = (state == DONE); res_data is held stable until res_valid & res_ready, then DONE -> IDLE.
REQ-019 SHALL: flush in ISSUE without handshake -> IDLE, with mul_valid low from the next cycle.
REQ-020 SHALL: flush in ISSUE coincident with mul_ready, or flush in WAIT -> DRAIN.
REQ-021 SHALL: DRAIN holds op_ready=0, waits for mul_out_valid, fills the cache, then -> IDLE, and never raises res_valid; flush is ignored in DRAIN.
REQ-022 SHALL: flush in WAIT coincident with mul_out_valid -> IDLE, cache filled, no res_valid.
REQ-023 SHALL: flush in DONE -> IDLE with the result dropped; flush in IDLE blocks accept for that cycle.
REQ-024 SHALL: multiplicand/multiplier driven only from latched registers, never directly from rs1/rs2.

Reset
REQ-025 SHALL: on rst state=IDLE; cache valid=0; res_data, latched operands and cache data = 0.
REQ-026 SHALL: after rst, outputs are op_ready=1, res_valid=0, mul_valid=0, mulw=0, mul_signed=0, multiplicand=0, multiplier=0.
REQ-027 SHALL: rst mid-operation abandons the op with no DRAIN, since the multiplier shares rst and resets in the same cycle.

Structure
REQ-028 SHALL: the mul_op enum (MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4) and the state enum live in the shared defines package.
REQ-029 SHALL: the controller instantiates ysyx_23060136_EXU_MUL as its single sub-module; the hit compare stays inline.

Verification
REQ-030 SHALL: MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB, res_ready=1 -> res_data=0xFFFF_FFFF_FFFF_FFF1, res_valid at cycle 7.
REQ-031 SHALL: MULHU 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; then MUL with the same operands -> hit, res_data=0x1 one cycle after accept, mul_valid never high.
REQ-032 SHALL: MULW 0x7FFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE; then MUL with the same operands -> miss (mulw differs) -> 0xFFFF_FFFE.
REQ-033 SHALL: flush in WAIT at cycle 3 -> DRAIN, op_ready=0 until cycle 7, no res_valid; next op is accepted at cycle 7.
REQ-034 SHALL: res_ready=0 for 5 cycles in DONE -> res_data and res_valid stable, op_ready=0; the release cycle returns to IDLE.
REQ-035 SHALL: rst in WAIT -> next cycle IDLE, op_ready=1; repeating the op misses (full 7-cycle latency).
